// File: rtl/carry_output_sequencer_if.sv
// Byte stream from the carry output sequencer toward the bitstream writer.
interface carry_output_sequencer_if #(
    parameter int W = 8
);
    logic [W-1:0] out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (output out_byte, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_byte, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/carry_output_sequencer.sv
// Buffers stage_4 carry groups in a small FIFO and serialises them one byte per accepted cycle (runs expanded).
// Group sampled at edge N appears on out_byte after edge N+1; output holds while out_ready=0, input side never stalls (overflow drops + sq_error).
module carry_output_sequencer #(
    parameter int SQ_BITSTREAM_WIDTH = 8,
    parameter int SQ_FIFO_DEPTH      = 4,
    parameter int SQ_FIFO_ADDR_WIDTH = 2
) (
    input  logic                          sq_clk,
    input  logic                          sq_reset,
    input  logic [2:0]                    in_carry_flag,
    input  logic [SQ_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
    input  logic [SQ_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
    input  logic [SQ_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
    input  logic [SQ_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
    input  logic [SQ_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
    input  logic                          in_flag_last,
    carry_output_sequencer_if.master      out_if,
    output logic                          sq_done,
    output logic                          sq_error
);
    localparam int W = SQ_BITSTREAM_WIDTH;
    localparam int A = SQ_FIFO_ADDR_WIDTH;
    localparam logic [W-1:0] RUN_ONE   = W'(1);
    localparam logic [A:0]   FIFO_FULL = (A+1)'(SQ_FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]   flag;
        logic [W-1:0] b1;
        logic [W-1:0] b2;
        logic [W-1:0] b3;
        logic [W-1:0] b4;
        logic [W-1:0] b5;
        logic         last;
    } grp_t;

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;
    typedef enum logic [2:0] {SL_B1, SL_B2, SL_B3, SL_B4, SL_B5} slot_t;

    typedef struct packed {
        logic  fin;
        slot_t nxt;
    } step_t;

    // Slot after the current byte; run is the b2 count still owed including this byte.
    function automatic step_t seq_next(input logic [2:0] flag, input slot_t slot, input logic [W-1:0] run);
        step_t s;
        s.fin = 1'b0;
        s.nxt = slot;
        case (slot)
            SL_B1: begin
                if (flag == 3'd1)                                   s.fin = 1'b1;
                else if (flag >= 3'd5 && run == '0 && flag == 3'd5) s.fin = 1'b1;
                else if (flag >= 3'd5 && run == '0)                 s.nxt = SL_B4;
                else                                                s.nxt = SL_B2;
            end
            SL_B2: begin
                if (flag >= 3'd5 && run > RUN_ONE)      s.nxt = SL_B2;
                else if (flag == 3'd2 || flag == 3'd5)  s.fin = 1'b1;
                else if (flag >= 3'd6)                  s.nxt = SL_B4;
                else                                    s.nxt = SL_B3;
            end
            SL_B3:   if (flag == 3'd3) s.fin = 1'b1; else s.nxt = SL_B4;
            SL_B4:   if (flag == 3'd7) s.nxt = SL_B5; else s.fin = 1'b1;
            default: s.fin = 1'b1;
        endcase
        return s;
    endfunction

    grp_t         mem_q [SQ_FIFO_DEPTH];
    logic [A-1:0] wr_ptr_q, rd_ptr_q;
    logic [A:0]   count_q, count_d;
    state_t       state_q, state_d;
    slot_t        slot_q, slot_d;
    grp_t         work_q, work_d;
    logic [W-1:0] run_q, run_d;
    logic         out_valid_q, out_last_q, done_q, error_q;
    logic [W-1:0] out_byte_q;

    grp_t         in_grp, head;
    step_t        nx;
    logic         empty, full, pop, push, drop, last_d;
    logic [W-1:0] byte_d;

    assign in_grp = {in_carry_flag, in_carry_bit_1, in_carry_bit_2, in_carry_bit_3,
                     in_carry_bit_4, in_carry_bit_5, in_flag_last};
    assign head   = mem_q[rd_ptr_q];
    assign empty  = (count_q == '0);
    assign full   = (count_q == FIFO_FULL);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        slot_d  = slot_q;
        run_d   = run_q;
        pop     = 1'b0;
        nx      = seq_next(work_q.flag, slot_q, run_q);
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    work_d  = head;
                    slot_d  = SL_B1;
                    run_d   = head.b3;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_if.out_ready) begin
                    if (slot_q == SL_B2) run_d = run_q - RUN_ONE;
                    if (!nx.fin) begin
                        slot_d = nx.nxt;
                    end else if (work_q.last) begin
                        state_d = ST_DONE;
                    end else if (!empty) begin
                        // back-to-back groups: reload on the same edge, no idle cycle
                        pop    = 1'b1;
                        work_d = head;
                        slot_d = SL_B1;
                        run_d  = head.b3;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        push = (in_carry_flag != 3'd0) && (state_q != ST_DONE) && (!full || pop);
        drop = (in_carry_flag != 3'd0) && !push;

        byte_d = '0;
        if (state_d == ST_EMIT) begin
            case (slot_d)
                SL_B1:   byte_d = work_d.b1;
                SL_B2:   byte_d = work_d.b2;
                SL_B3:   byte_d = work_d.b3;
                SL_B4:   byte_d = work_d.b4;
                default: byte_d = work_d.b5;
            endcase
        end
        last_d = (state_d == ST_EMIT) && work_d.last && seq_next(work_d.flag, slot_d, run_d).fin;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sq_clk) begin
        if (sq_reset && push) mem_q[wr_ptr_q] <= in_grp;
    end

    always_ff @(posedge sq_clk) begin
        if (!sq_reset) begin
            state_q     <= ST_IDLE;
            slot_q      <= SL_B1;
            work_q      <= '0;
            run_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            work_q      <= work_d;
            run_q       <= run_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            out_valid_q <= (state_d == ST_EMIT);
            out_byte_q  <= byte_d;
            out_last_q  <= last_d;
            done_q      <= done_q | (state_d == ST_DONE);
            error_q     <= error_q | drop;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_byte  = out_byte_q;
    assign out_if.out_last  = out_last_q;
    assign sq_done          = done_q;
    assign sq_error         = error_q;
endmodule
